// File: rtl/im_loader_if.sv
// ---------------------------------------------------------------------------
// im_loader_if
// Byte-stream input, instruction-memory write port and processor control
// signals shared by the program loader and whatever drives or observes it.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface im_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [DATA_W-1:0] im_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  // Stream source / system controller side
  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, im_we, im_waddr, im_wdata, cpu_hold, done, err
  );

  // Loader side
  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, im_we, im_waddr, im_wdata, cpu_hold, done, err
  );
endinterface

`default_nettype wire

// File: rtl/im_loader.sv
// ---------------------------------------------------------------------------
// im_loader
// Accepts a length / payload / checksum byte stream and writes the payload
// into the instruction memory at consecutive addresses starting at
// BASE_ADDR. The processor is held until a load finishes with a matching
// checksum.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module im_loader #(
  parameter int         IM_ADDR_W_m1 = 7,
  parameter int         IM_DATA_W_m1 = 7,
  parameter logic [7:0] BASE_ADDR    = 8'h00
) (
  input wire logic    clk,
  input wire logic    rst_n,
  im_loader_if.slave  ldr
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t                r_state;
  logic [8:0]            r_remaining;
  logic [7:0]            r_index;
  logic [7:0]            r_sum;
  logic                  r_byte_ready;
  logic                  r_im_we;
  logic [IM_ADDR_W_m1:0] r_im_waddr;
  logic [IM_DATA_W_m1:0] r_im_wdata;
  logic                  r_cpu_hold;
  logic                  r_done;
  logic                  r_err;

  logic                  w_accept;
  logic [7:0]            w_addr8;

  // byte_ready is registered and high only in LEN/DATA/CSUM, so it doubles
  // as the "state accepts bytes" qualifier.
  assign w_accept = ldr.byte_valid & r_byte_ready;
  // 8-bit add gives the modulo-256 address wrap for free.
  assign w_addr8  = BASE_ADDR + r_index;

  // Loader FSM with all outputs registered; start overrides everything,
  // including a byte presented on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_remaining  <= 9'd0;
      r_index      <= 8'd0;
      r_sum        <= 8'd0;
      r_byte_ready <= 1'b0;
      r_im_we      <= 1'b0;
      r_im_waddr   <= '0;
      r_im_wdata   <= '0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_im_we <= 1'b0;
      if (ldr.start) begin
        r_state      <= S_LEN;
        r_remaining  <= 9'd0;
        r_index      <= 8'd0;
        r_sum        <= 8'd0;
        r_byte_ready <= 1'b1;
        r_cpu_hold   <= 1'b1;
        r_done       <= 1'b0;
        r_err        <= 1'b0;
      end else begin
        case (r_state)
          S_LEN: begin
            if (w_accept) begin
              // A zero length byte encodes a full 256-byte image
              r_remaining <= (ldr.byte_data == 8'd0) ? 9'd256 : {1'b0, ldr.byte_data};
              r_state     <= S_DATA;
            end
          end
          S_DATA: begin
            if (w_accept) begin
              r_im_we     <= 1'b1;
              r_im_waddr  <= (IM_ADDR_W_m1 + 1)'(w_addr8);
              r_im_wdata  <= (IM_DATA_W_m1 + 1)'(ldr.byte_data);
              r_index     <= r_index + 8'd1;
              r_sum       <= r_sum + ldr.byte_data;
              r_remaining <= r_remaining - 9'd1;
              if (r_remaining == 9'd1) begin
                r_state <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            if (w_accept) begin
              r_byte_ready <= 1'b0;
              if (ldr.byte_data == r_sum) begin
                r_state    <= S_DONE;
                r_done     <= 1'b1;
                r_cpu_hold <= 1'b0;
              end else begin
                r_state    <= S_ERR;
                r_err      <= 1'b1;
                r_cpu_hold <= 1'b1;
              end
            end
          end
          S_IDLE, S_DONE, S_ERR: begin
            // Terminal/idle states wait for start; stream bytes are ignored
            r_byte_ready <= 1'b0;
          end
          default: begin
            r_state      <= S_IDLE;
            r_byte_ready <= 1'b0;
            r_cpu_hold   <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ldr.byte_ready = r_byte_ready;
  assign ldr.im_we      = r_im_we;
  assign ldr.im_waddr   = r_im_waddr;
  assign ldr.im_wdata   = r_im_wdata;
  assign ldr.cpu_hold   = r_cpu_hold;
  assign ldr.done       = r_done;
  assign ldr.err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_im_loader.sv
// ---------------------------------------------------------------------------
// tb_im_loader
// Randomised stream stimulus with a queue-based scoreboard for IM writes and
// load outcomes.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_im_loader;

  localparam logic [7:0] TB_BASE = 8'hFE;

  logic clk;
  logic rst_n;

  im_loader_if #(.ADDR_W(8), .DATA_W(8)) ldr ();

  im_loader #(
    .IM_ADDR_W_m1 (7),
    .IM_DATA_W_m1 (7),
    .BASE_ADDR    (TB_BASE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ldr   (ldr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard queues: expected {addr,data} writes and {done,err,hold} outcomes
  logic [15:0] q_wr[$];
  logic [2:0]  q_st[$];
  logic [7:0]  g_pay[$];

  logic [15:0] exp_wr;
  logic [2:0]  exp_st;
  logic        prev_term = 1'b0;

  // Monitor: compares every write strobe and every completion against the queues
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_term = 1'b0;
    end else begin
      if (ldr.im_we) begin
        n_cmp++;
        if (q_wr.size() == 0) begin
          n_bad++;
          $display("FAIL write_unexpected: got addr=%h data=%h, required no write", ldr.im_waddr, ldr.im_wdata);
        end else begin
          exp_wr = q_wr.pop_front();
          if ({ldr.im_waddr, ldr.im_wdata} !== exp_wr) begin
            n_bad++;
            $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                     ldr.im_waddr, ldr.im_wdata, exp_wr[15:8], exp_wr[7:0]);
          end
        end
      end
      if ((ldr.done | ldr.err) && !prev_term) begin
        n_cmp++;
        if (q_st.size() == 0) begin
          n_bad++;
          $display("FAIL status_unexpected: got done=%b err=%b", ldr.done, ldr.err);
        end else begin
          exp_st = q_st.pop_front();
          if ({ldr.done, ldr.err, ldr.cpu_hold} !== exp_st) begin
            n_bad++;
            $display("FAIL status: got done/err/hold=%b, required %b",
                     {ldr.done, ldr.err, ldr.cpu_hold}, exp_st);
          end
        end
      end
      prev_term = ldr.done | ldr.err;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ldr.start = 1'b1;
    tick();
    ldr.start = 1'b0;
  endtask

  // Present one byte after an optional random idle gap; return once accepted
  task automatic send(input logic [7:0] b, input int maxgap);
    int gap;
    int n;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    ldr.byte_valid = 1'b0;
    repeat (gap) tick();
    ldr.byte_valid = 1'b1;
    ldr.byte_data  = b;
    n = 0;
    while (!ldr.byte_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: byte %h never accepted", b);
    end
    tick();
    ldr.byte_valid = 1'b0;
    ldr.byte_data  = $urandom();
  endtask

  // Full load from g_pay; the reference is plain arithmetic over the payload
  task automatic do_load(input logic [7:0] len, input logic [7:0] csum, input int maxgap);
    logic [7:0] sum;
    int n;
    pulse_start();
    send(len, maxgap);
    sum = 8'd0;
    for (int i = 0; i < g_pay.size(); i++) begin
      q_wr.push_back({8'(TB_BASE + i), g_pay[i]});
      sum = sum + g_pay[i];
      send(g_pay[i], maxgap);
    end
    q_st.push_back((csum == sum) ? 3'b100 : 3'b011);
    send(csum, maxgap);
    n = 0;
    while (!(ldr.done | ldr.err) && n < 10) begin
      tick();
      n++;
    end
    if (n >= 10) begin
      n_cmp++;
      n_bad++;
      $display("FAIL completion_timeout: no done/err after checksum");
    end
    tick();
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {24'd0, ldr.byte_ready, ldr.im_we, ldr.cpu_hold, ldr.done, ldr.err, 3'b0},
          {24'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b0});
    check({name, "_bus"}, {16'd0, ldr.im_waddr, ldr.im_wdata}, 32'd0);
  endtask

  initial begin
    logic [7:0] len;
    logic [7:0] sum;
    ldr.start      = 1'b0;
    ldr.byte_valid = 1'b0;
    ldr.byte_data  = 8'h00;
    rst_n          = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // IDLE ignores a valid byte
    ldr.byte_valid = 1'b1;
    ldr.byte_data  = 8'h5A;
    repeat (4) begin
      tick();
      check("idle_ready", {31'd0, ldr.byte_ready}, 32'd0);
    end
    ldr.byte_valid = 1'b0;

    // Basic load
    g_pay = '{8'h11, 8'h22, 8'h33};
    do_load(8'h03, 8'h66, 0);
    check("basic_hold", {31'd0, ldr.cpu_hold}, 32'd0);

    // DONE ignores valid bytes and keeps its outputs
    ldr.byte_valid = 1'b1;
    repeat (5) begin
      ldr.byte_data = $urandom();
      tick();
      check("done_ready", {30'd0, ldr.byte_ready, ldr.done}, 32'd1);
    end
    ldr.byte_valid = 1'b0;

    // Checksum error, then a good load
    g_pay = '{8'h10, 8'h20};
    do_load(8'h02, 8'h31, 0);
    check("err_hold", {31'd0, ldr.cpu_hold}, 32'd1);
    g_pay = '{8'h05};
    do_load(8'h01, 8'h05, 0);

    // 256-byte load across the address wrap
    g_pay = {};
    for (int i = 0; i < 256; i++) g_pay.push_back(8'(i));
    do_load(8'h00, 8'h80, 0);

    // Backpressure gaps on a 4-byte load
    g_pay = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_load(8'h04, 8'h4A, 4);

    // Random loads, some with a corrupted checksum
    repeat (4) begin
      len = 8'($urandom_range(20, 1));
      g_pay = {};
      sum = 8'd0;
      for (int i = 0; i < int'(len); i++) begin
        g_pay.push_back(8'($urandom()));
        sum = sum + g_pay[i];
      end
      if ($urandom_range(3, 0) == 0) sum = sum ^ 8'(1 << $urandom_range(7, 0));
      do_load(len, sum, 3);
    end

    // start during DATA drops the same-edge byte and restarts index/sum
    pulse_start();
    send(8'h04, 0);
    q_wr.push_back({TB_BASE, 8'h91});
    send(8'h91, 0);
    q_wr.push_back({8'(TB_BASE + 1), 8'h92});
    send(8'h92, 0);
    ldr.start      = 1'b1;
    ldr.byte_valid = 1'b1;
    ldr.byte_data  = 8'h77;
    tick();
    ldr.start      = 1'b0;
    ldr.byte_valid = 1'b0;
    check("restart_hold", {31'd0, ldr.cpu_hold}, 32'd1);
    send(8'h02, 0);
    q_wr.push_back({TB_BASE, 8'hAA});
    send(8'hAA, 0);
    q_wr.push_back({8'(TB_BASE + 1), 8'h55});
    send(8'h55, 0);
    q_st.push_back(3'b100);
    send(8'hFF, 0);
    repeat (3) tick();
    check("restart_done", {31'd0, ldr.done}, 32'd1);

    // Asynchronous reset after the 2nd payload byte of a 5-byte load
    pulse_start();
    send(8'h05, 0);
    q_wr.push_back({TB_BASE, 8'h01});
    send(8'h01, 0);
    q_wr.push_back({8'(TB_BASE + 1), 8'h02});
    send(8'h02, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_reset_idle", {29'd0, ldr.byte_ready, ldr.done, ldr.cpu_hold}, 32'd1);

    check("writes_left", q_wr.size(), 32'd0);
    check("status_left", q_st.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
